plab5_mcore_mem_resp_cmsg_unpack_queue: RTL

Responder-to-initiator return path for split memory messages: accepts packed memory-response control messages (type, opaque, len; no data) on a val/rdy channel, buffers them in a 2-entry queue, and presents the unpacked fields plus an expanded byte count to the consuming core or cache on a second val/rdy channel. It sits at the initiator end of the response network. It is the receive-side counterpart of the response control-message packer at the memory end.

---
 rtl/plab5_mcore_mem_resp_cmsg_unpack_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/plab5_mcore_mem_resp_cmsg_unpack_queue.sv
//------------------------------------------------------------------------------
// Module   : plab5_mcore_mem_resp_cmsg_unpack_queue
// Purpose  : Initiator-side receive queue for memory-response control messages.
//            Accepts packed {type, opaque, len} messages on a val/rdy channel,
//            holds up to two of them, and presents the head entry unpacked,
//            plus the byte count implied by len, on a second val/rdy channel.
// Ports    : clk           - clock, all state on rising edge
//            rst_n         - asynchronous active-low reset
//            in_msg_i      - packed message {type[2:0], opaque, len}
//            in_val_i      - in_msg_i valid
//            in_rdy_o      - queue can accept (not full)
//            out_type_o    - head entry type
//            out_opaque_o  - head entry opaque
//            out_len_o     - head entry raw len
//            out_nbytes_o  - head entry byte count (len 0 means full data width)
//            out_val_o     - head entry valid
//            out_rdy_i     - consumer accepts head
//            num_entries_o - occupancy, 0..2
//            err_o         - sticky illegal-type flag
// Options  : PLAB5_MCORE_MEM_RESP_CHECK_EN - when defined, err_o sets on any
//            enqueued message whose type is above 2 and holds until reset.
//            When undefined, err_o is tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module plab5_mcore_mem_resp_cmsg_unpack_queue #(
  parameter  int p_opaque_nbits = 8,
  parameter  int p_data_nbits   = 32,
  localparam int c_len_nbits    = $clog2(p_data_nbits/8),
  localparam int c_msg_nbits    = 3 + p_opaque_nbits + c_len_nbits
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [c_msg_nbits-1:0]    in_msg_i,
  input  logic                      in_val_i,
  output logic                      in_rdy_o,
  output logic [2:0]                out_type_o,
  output logic [p_opaque_nbits-1:0] out_opaque_o,
  output logic [c_len_nbits-1:0]    out_len_o,
  output logic [c_len_nbits:0]      out_nbytes_o,
  output logic                      out_val_o,
  input  logic                      out_rdy_i,
  output logic [1:0]                num_entries_o,
  output logic                      err_o
);

  localparam logic [c_len_nbits:0] c_max_nbytes = (c_len_nbits+1)'(p_data_nbits/8);

  logic [c_msg_nbits-1:0] entry_q [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   full_q,   full_d;

  logic                   empty;
  logic                   enq;
  logic                   deq;
  logic [c_msg_nbits-1:0] head;

  // With one-bit pointers, equal pointers mean either empty or full; the
  // full flag disambiguates.
  assign empty = !full_q && (wr_ptr_q == rd_ptr_q);

  // Both ready and valid come from registered state only, so there is no
  // combinational path from out_rdy_i to in_rdy_o or from in_msg_i to out_*.
  assign in_rdy_o  = !full_q;
  assign out_val_o = !empty;

  assign enq = in_val_i && !full_q;
  assign deq = !empty && out_rdy_i;

  always_comb begin
    wr_ptr_d = enq ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = deq ? ~rd_ptr_q : rd_ptr_q;
    full_d   = full_q;
    if (enq && !deq) begin
      // Enqueue alone fills the queue when the write pointer catches the read pointer.
      full_d = (wr_ptr_d == rd_ptr_q);
    end else if (deq && !enq) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_q[wr_ptr_q] <= in_msg_i;
    end
  end

  assign head          = entry_q[rd_ptr_q];
  assign out_type_o    = head[c_msg_nbits-1 -: 3];
  assign out_opaque_o  = head[c_len_nbits +: p_opaque_nbits];
  assign out_len_o     = head[c_len_nbits-1:0];

  // A zero length field encodes a full-width transfer.
  assign out_nbytes_o  = (out_len_o == '0) ? c_max_nbytes : {1'b0, out_len_o};

  assign num_entries_o = full_q ? 2'd2 : {1'b0, !empty};

`ifdef PLAB5_MCORE_MEM_RESP_CHECK_EN
  logic err_q;

  // Only read (0), write (1) and write-init (2) are legal response types.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (enq && (in_msg_i[c_msg_nbits-1 -: 3] > 3'd2)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire
